// File: rtl/ifu_pkg.sv
// Shared constants and width helpers for the prefetching instruction-fetch unit.
package ifu_pkg;

   localparam logic [1:0] RESP_OKAY = 2'b00;

   // Bits needed to hold a count in the range 0..n.
   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Generic synchronous FIFO with flush. Depth need not be a power of two.
module ifu_fifo
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4,
   localparam int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic [WIDTH-1:0] dout,
   output logic [CNT_W-1:0] count
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_push;
   logic             do_pop;

   function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign do_pop  = pop && (count != '0);
   assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= ptr_next(wr_ptr);
         if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
         count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push && !flush) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/ifu_prefetch.sv
// Prefetching fetch unit: autonomous sequential AXI-lite reads, instruction queue
// towards the IDU, and in-order discard of responses that predate a redirect.
module ifu_prefetch
   import ifu_pkg::*;
#(
   parameter int                ADDR_W          = 32,
   parameter int                DATA_W          = 32,
   parameter logic [ADDR_W-1:0] RESET_PC        = 32'h8000_0000,
   parameter int                MAX_OUTSTANDING = 2,
   parameter int                IBUF_DEPTH      = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic [ADDR_W-1:0] araddr,
   output logic              arvalid,
   input  logic              arready,
   input  logic [DATA_W-1:0] rdata,
   input  logic [1:0]        rresp,
   input  logic              rvalid,
   output logic              rready,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_inst,
   output logic [ADDR_W-1:0] out_pc,
   output logic              out_fault
);

   localparam int INF_W   = cnt_w(MAX_OUTSTANDING);
   localparam int CNT_W   = cnt_w(IBUF_DEPTH);
   localparam int SUM_W   = cnt_w(MAX_OUTSTANDING + IBUF_DEPTH);
   localparam int ENTRY_W = ADDR_W + DATA_W + 1;

   typedef struct packed {
      logic [ADDR_W-1:0] pc;
      logic [DATA_W-1:0] inst;
      logic              fault;
   } ibuf_entry_t;

   logic [ADDR_W-1:0] fetch_pc;
   logic [INF_W-1:0]  inflight;
   logic [INF_W-1:0]  drop_cnt;
   logic              halted;
   logic [CNT_W-1:0]  ibuf_count;
   logic [ADDR_W-1:0] beat_pc;
   ibuf_entry_t       ibuf_din;
   ibuf_entry_t       ibuf_head;
   logic              launch;
   logic              beat;
   logic              beat_fault;
   logic              ibuf_push;
   logic              ibuf_pop;

   assign rready     = rst_n;
   assign beat       = rvalid && rready;
   assign beat_fault = (rresp != RESP_OKAY);

   // Credit covers both launched reads and queued entries, so every beat has a slot.
   assign launch = (!arvalid || arready) && !halted && !redirect_valid
                && (inflight < INF_W'(MAX_OUTSTANDING))
                && ((SUM_W'(inflight) + SUM_W'(ibuf_count)) < SUM_W'(IBUF_DEPTH));

   assign ibuf_push = beat && (drop_cnt == '0) && !redirect_valid;
   assign ibuf_pop  = out_valid && out_ready;

   always_comb begin
      ibuf_din.pc    = beat_pc;
      ibuf_din.inst  = beat_fault ? '0 : rdata;
      ibuf_din.fault = beat_fault;
   end

   // PC side-queue pops on every beat, dropped or not, so its occupancy is the in-flight count.
   ifu_fifo #(.WIDTH(ADDR_W), .DEPTH(MAX_OUTSTANDING)) u_pc_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (1'b0),
      .push  (launch),
      .din   (fetch_pc),
      .pop   (beat),
      .dout  (beat_pc),
      .count (inflight)
   );

   ifu_fifo #(.WIDTH(ENTRY_W), .DEPTH(IBUF_DEPTH)) u_ibuf (
      .clk   (clk),
      .rst_n (rst_n),
      .flush (redirect_valid),
      .push  (ibuf_push),
      .din   (ibuf_din),
      .pop   (ibuf_pop),
      .dout  (ibuf_head),
      .count (ibuf_count)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         arvalid  <= 1'b0;
         araddr   <= '0;
         fetch_pc <= RESET_PC;
         halted   <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (launch) begin
            arvalid  <= 1'b1;
            araddr   <= fetch_pc;
            fetch_pc <= fetch_pc + ADDR_W'(4);
         end else if (arready) begin
            arvalid  <= 1'b0;
         end
         if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            halted   <= 1'b0;
            drop_cnt <= inflight - INF_W'(beat);
         end else begin
            if (beat && (drop_cnt != '0)) drop_cnt <= drop_cnt - INF_W'(1);
            if (ibuf_push && beat_fault)  halted   <= 1'b1;
         end
      end
   end

   // Head fields are forced to zero while empty so the uninitialised queue never leaks out.
   assign out_valid = (ibuf_count != '0);
   assign out_pc    = out_valid ? ibuf_head.pc    : '0;
   assign out_inst  = out_valid ? ibuf_head.inst  : '0;
   assign out_fault = out_valid ? ibuf_head.fault : 1'b0;

endmodule

// File: tb/tb_ifu_prefetch.sv
// Directed bench for ifu_prefetch with a 1-cycle-latency memory returning addr ^ 0xFFFF.
module tb_ifu_prefetch;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic [31:0] araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_fault;

   always #5 clk = ~clk;

   ifu_prefetch #(
      .ADDR_W(32), .DATA_W(32), .RESET_PC(32'h8000_0000),
      .MAX_OUTSTANDING(2), .IBUF_DEPTH(4)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .araddr         (araddr),
      .arvalid        (arvalid),
      .arready        (arready),
      .rdata          (rdata),
      .rresp          (rresp),
      .rvalid         (rvalid),
      .rready         (rready),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_inst       (out_inst),
      .out_pc         (out_pc),
      .out_fault      (out_fault)
   );

   int          n_cmp = 0;
   int          n_err = 0;
   int          launches = 0;
   int          beats = 0;
   int          max_infl = 0;
   logic        fault_en = 1'b0;
   logic [31:0] fault_addr = 32'h0;
   logic [31:0] got_pc [$];
   logic [31:0] got_inst [$];
   logic        got_fault [$];
   logic [31:0] launch_addr [$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // One clock: sample handshakes before the edge, then update the memory model after it.
   task automatic cycle();
      logic        fire;
      logic        pav;
      logic [31:0] a;
      #1;
      fire = arvalid && arready;
      pav  = arvalid;
      a    = araddr;
      if (rvalid && rready) beats++;
      if (out_valid && out_ready) begin
         got_pc.push_back(out_pc);
         got_inst.push_back(out_inst);
         got_fault.push_back(out_fault);
      end
      @(posedge clk);
      #1;
      if (arvalid && (!pav || fire)) begin
         launches++;
         launch_addr.push_back(araddr);
      end
      if (launches - beats > max_infl) max_infl = launches - beats;
      rvalid = fire;
      rdata  = a ^ 32'h0000_FFFF;
      rresp  = (fault_en && (a == fault_addr)) ? 2'b10 : 2'b00;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) cycle();
   endtask

   task automatic clear_got();
      got_pc.delete();
      got_inst.delete();
      got_fault.delete();
   endtask

   task automatic check_seq(input string tag, input logic [31:0] base, input int n_min);
      logic [31:0] e;
      chk({tag, "_count_ok"}, 64'(got_pc.size() >= n_min), 64'd1);
      for (int i = 0; i < got_pc.size(); i++) begin
         e = base + 32'(4 * i);
         chk($sformatf("%s_pc%0d", tag, i), 64'(got_pc[i]), 64'(e));
         chk($sformatf("%s_inst%0d", tag, i), 64'(got_inst[i]), 64'(e ^ 32'h0000_FFFF));
         chk($sformatf("%s_fault%0d", tag, i), 64'(got_fault[i]), 64'd0);
      end
   endtask

   task automatic wait_ar_and_r(input string tag);
      int n = 0;
      while (!(arvalid && rvalid) && n < 20) begin
         cycle();
         n++;
      end
      chk({tag, "_sync"}, 64'(arvalid && rvalid), 64'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          base_l;
      logic [31:0] exp_ar;

      rst_n = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      arready = 1'b1; rvalid = 1'b0; rdata = '0; rresp = '0; out_ready = 1'b1;
      run(3);
      chk("rst_arvalid",   64'(arvalid),   64'd0);
      chk("rst_araddr",    64'(araddr),    64'd0);
      chk("rst_rready",    64'(rready),    64'd0);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_out_inst",  64'(out_inst),  64'd0);
      chk("rst_out_pc",    64'(out_pc),    64'd0);
      chk("rst_out_fault", 64'(out_fault), 64'd0);

      // Sequential fetch and first-beat latency
      rst_n = 1'b1;
      cycle();
      chk("t1_first_arvalid", 64'(arvalid), 64'd1);
      chk("t1_first_araddr",  64'(araddr),  64'h8000_0000);
      chk("t1_rready",        64'(rready),  64'd1);
      chk("t1_out_valid_c1",  64'(out_valid), 64'd0);
      cycle();
      chk("t1_rvalid_c2",     64'(rvalid),    64'd1);
      chk("t1_out_valid_c2",  64'(out_valid), 64'd0);
      cycle();
      chk("t1_out_valid_c3",  64'(out_valid), 64'd1);
      chk("t1_out_pc_c3",     64'(out_pc),    64'h8000_0000);
      chk("t1_out_inst_c3",   64'(out_inst),  64'h8000_FFFF);
      chk("t1_out_fault_c3",  64'(out_fault), 64'd0);
      run(12);

      // Back-pressure fills exactly IBUF_DEPTH entries
      out_ready = 1'b0;
      run(10);
      chk("t2_queued",      64'(beats - got_pc.size()), 64'd4);
      chk("t2_arvalid_off", 64'(arvalid), 64'd0);
      chk("t2_inflight",    64'(launches - beats), 64'd0);
      chk("t2_out_valid",   64'(out_valid), 64'd1);
      chk("t2_head_pc",     64'(out_pc), 64'(32'h8000_0000 + 32'(4 * got_pc.size())));
      out_ready = 1'b1;
      run(12);

      // AR stall: request held stable
      begin
         int n = 0;
         while (!arvalid && n < 10) begin cycle(); n++; end
      end
      chk("t3_pre_arvalid", 64'(arvalid), 64'd1);
      exp_ar  = 32'h8000_0000 + 32'(4 * (launches - 1));
      arready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk($sformatf("t3_arvalid%0d", i), 64'(arvalid), 64'd1);
         chk($sformatf("t3_araddr%0d", i),  64'(araddr),  64'(exp_ar));
      end
      arready = 1'b1;
      run(10);
      check_seq("seq", 32'h8000_0000, 25);
      for (int i = 0; i < launch_addr.size(); i++)
         chk($sformatf("seq_ar%0d", i), 64'(launch_addr[i]), 64'(32'h8000_0000 + 32'(4 * i)));

      // Redirect with two reads in flight
      wait_ar_and_r("t4");
      chk("t4_inflight_pre", 64'(launches - beats), 64'd2);
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0100;
      cycle();
      redirect_valid = 1'b0;
      chk("t4_out_valid_flushed", 64'(out_valid), 64'd0);
      chk("t4_arvalid_idle",      64'(arvalid),   64'd0);
      clear_got();
      base_l = launches;
      run(10);
      chk("t4_first_ar", 64'((launch_addr.size() > base_l) ? launch_addr[base_l] : 32'h0), 64'h8000_0100);
      check_seq("t4", 32'h8000_0100, 5);

      // Redirect coinciding with an R beat and a stalled AR
      wait_ar_and_r("t5");
      exp_ar  = 32'h8000_0100 + 32'(4 * (launches - base_l - 1));
      arready = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0200;
      cycle();
      redirect_valid = 1'b0;
      chk("t5_out_valid_flushed", 64'(out_valid), 64'd0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) cycle();
         chk($sformatf("t5_arvalid%0d", i), 64'(arvalid), 64'd1);
         chk($sformatf("t5_araddr%0d", i),  64'(araddr),  64'(exp_ar));
      end
      clear_got();
      base_l  = launches;
      arready = 1'b1;
      run(10);
      chk("t5_first_ar", 64'((launch_addr.size() > base_l) ? launch_addr[base_l] : 32'h0), 64'h8000_0200);
      check_seq("t5", 32'h8000_0200, 5);

      // Fault on 0x8000_0008 halts fetch until the next redirect
      fault_en = 1'b1; fault_addr = 32'h8000_0008;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0000;
      cycle();
      redirect_valid = 1'b0;
      clear_got();
      run(14);
      chk("t6_count_ok", 64'(got_pc.size() >= 3), 64'd1);
      if (got_pc.size() >= 3) begin
         chk("t6_pc0",    64'(got_pc[0]),    64'h8000_0000);
         chk("t6_inst0",  64'(got_inst[0]),  64'h8000_FFFF);
         chk("t6_fault0", 64'(got_fault[0]), 64'd0);
         chk("t6_pc1",    64'(got_pc[1]),    64'h8000_0004);
         chk("t6_fault1", 64'(got_fault[1]), 64'd0);
         chk("t6_pc2",    64'(got_pc[2]),    64'h8000_0008);
         chk("t6_inst2",  64'(got_inst[2]),  64'd0);
         chk("t6_fault2", 64'(got_fault[2]), 64'd1);
      end
      for (int i = 0; i < 4; i++) begin
         cycle();
         chk($sformatf("t6_halt_arvalid%0d", i), 64'(arvalid), 64'd0);
      end
      chk("t6_drained", 64'(out_valid), 64'd0);
      fault_en = 1'b0;
      redirect_valid = 1'b1; redirect_pc = 32'h8000_0300;
      cycle();
      redirect_valid = 1'b0;
      clear_got();
      base_l = launches;
      run(10);
      chk("t6_restart_ar", 64'((launch_addr.size() > base_l) ? launch_addr[base_l] : 32'h0), 64'h8000_0300);
      check_seq("t6r", 32'h8000_0300, 3);
      chk("max_inflight_le_2", 64'(max_infl <= 2), 64'd1);

      // Mid-operation reset
      rst_n = 1'b0;
      run(2);
      chk("t7_arvalid",   64'(arvalid),   64'd0);
      chk("t7_araddr",    64'(araddr),    64'd0);
      chk("t7_rready",    64'(rready),    64'd0);
      chk("t7_out_valid", 64'(out_valid), 64'd0);
      chk("t7_out_pc",    64'(out_pc),    64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
